// File: rtl/mips_avalon_ram.sv
// Avalon-MM slave RAM with a fixed number of wait states per operation and
// a SLAVEERROR response for out-of-window, misaligned or ambiguous accesses.
module mips_avalon_ram #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] ADDR_START  = 32'hBFC00000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          READ_DELAY  = 2,
    parameter int          WRITE_DELAY = READ_DELAY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic [1:0]              response
);
    localparam int          BYTES  = DATA_WIDTH / 8;
    localparam int          OFFS_W = $clog2(BYTES);
    localparam int          IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] WINDOW = 32'(MEM_WORDS * BYTES);
    localparam int          MAXD   = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int          CW     = $clog2(MAXD + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          ctr_q, ctr_d;
    logic [IDX_W-1:0]       idx_q;
    logic                   is_wr_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BYTES-1:0]       be_q;
    logic [1:0]             response_q;

    // Decode of the request as presented on the bus this cycle.
    logic                   req;
    logic [31:0]            acc_offset;
    logic                   acc_err;
    logic                   acc_write;
    int                     acc_delay;
    logic [IDX_W-1:0]       acc_idx;

    assign req        = read | write;
    assign acc_offset = address - ADDR_START;
    assign acc_err    = (address < ADDR_START) || (acc_offset >= WINDOW)
                     || ((address & 32'(BYTES - 1)) != 32'd0) || (read && write);
    assign acc_write  = write & ~read;
    assign acc_delay  = acc_write ? WRITE_DELAY : READ_DELAY;
    assign acc_idx    = IDX_W'(acc_offset >> OFFS_W);

    // A one-cycle access reaches ACK before the latches are loaded, so the
    // live decode is used while still in IDLE.
    logic                   eff_err;
    logic                   eff_wr;
    logic [IDX_W-1:0]       eff_idx;
    logic                   enter_ack;
    logic                   load_rd;
    logic                   commit;

    assign eff_err   = (state_q == S_IDLE) ? acc_err   : err_q;
    assign eff_wr    = (state_q == S_IDLE) ? acc_write : is_wr_q;
    assign eff_idx   = (state_q == S_IDLE) ? acc_idx   : idx_q;
    assign enter_ack = (state_d == S_ACK) && !rst;
    assign load_rd   = enter_ack && (!eff_wr || eff_err);
    assign commit    = (state_q == S_ACK) && is_wr_q && !err_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (acc_delay == 1) begin
                        state_d = S_ACK;
                        ctr_d   = '0;
                    end else begin
                        state_d = S_WAIT;
                        ctr_d   = CW'(acc_delay - 2);
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    ctr_d   = '0;
                end else if (ctr_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    ctr_d = ctr_q - CW'(1);
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        waitrequest = req && (state_q != S_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            is_wr_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            response_q <= 2'b00;
        end else begin
            if (state_q == S_IDLE && req) begin
                idx_q   <= acc_idx;
                is_wr_q <= acc_write;
                err_q   <= acc_err;
                wdata_q <= writedata;
                be_q    <= byteenable;
            end
            response_q <= (enter_ack && eff_err) ? 2'b10 : 2'b00;
        end
    end

    assign response = response_q;

    // One narrow RAM per byte lane keeps lane writes independent.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (commit && be_q[gi]) begin
                lane_mem[idx_q] <= wdata_q[8*gi +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= 8'h00;
            end else if (load_rd) begin
                rd_q <= eff_err ? 8'h00 : lane_mem[eff_idx];
            end
        end

        assign readdata[8*gi +: 8] = rd_q;
    end
endmodule

// File: tb/tb_mips_avalon_ram.sv
// Directed bench: a 32-bit RAM (read 2 / write 3 waits) and a 64-bit RAM
// (1 wait) on a shared clock and reset.
module tb_mips_avalon_ram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_address = '0;
    logic        a_read = 1'b0, a_write = 1'b0;
    logic [31:0] a_writedata = '0;
    logic [3:0]  a_byteenable = '0;
    logic        a_wait;
    logic [31:0] a_readdata;
    logic [1:0]  a_response;

    logic [31:0] b_address = '0;
    logic        b_read = 1'b0, b_write = 1'b0;
    logic [63:0] b_writedata = '0;
    logic [7:0]  b_byteenable = '0;
    logic        b_wait;
    logic [63:0] b_readdata;
    logic [1:0]  b_response;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_avalon_ram #(
        .DATA_WIDTH(32), .ADDR_START(32'hBFC00000), .MEM_WORDS(1024),
        .READ_DELAY(2), .WRITE_DELAY(3)
    ) dut_a (
        .clk(clk), .rst(rst), .address(a_address), .read(a_read), .write(a_write),
        .writedata(a_writedata), .byteenable(a_byteenable), .waitrequest(a_wait),
        .readdata(a_readdata), .response(a_response)
    );

    mips_avalon_ram #(
        .DATA_WIDTH(64), .ADDR_START(32'hBFC00000), .MEM_WORDS(16),
        .READ_DELAY(1)
    ) dut_b (
        .clk(clk), .rst(rst), .address(b_address), .read(b_read), .write(b_write),
        .writedata(b_writedata), .byteenable(b_byteenable), .waitrequest(b_wait),
        .readdata(b_readdata), .response(b_response)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
        int          exp_w;   // -1: wait count not checked
        bit          chk_rd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [31:0] wd,
                                logic [3:0] be, logic [31:0] exp_rd, logic [1:0] exp_resp,
                                int exp_w, bit chk_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.be = be;
        v.exp_rd = exp_rd; v.exp_resp = exp_resp; v.exp_w = exp_w; v.chk_rd = chk_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] be,
                        output logic [63:0] rdata, output logic [1:0] resp, output int waits);
        bit done;
        @(posedge clk); #1;
        if (sel) begin
            b_address = addr; b_read = rd; b_write = wr; b_writedata = wd; b_byteenable = be;
        end else begin
            a_address = addr; a_read = rd; a_write = wr; a_writedata = wd[31:0]; a_byteenable = be[3:0];
        end
        waits = 0;
        done  = 1'b0;
        rdata = '0;
        resp  = 2'b11;
        while (!done) begin
            @(negedge clk);
            if (!(sel ? b_wait : a_wait)) begin
                rdata = sel ? b_readdata : {32'h0, a_readdata};
                resp  = sel ? b_response : a_response;
                done  = 1'b1;
            end else begin
                waits++;
                if (waits > 20) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL timeout: waitrequest still high after %0d cycles, expected release", waits);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
    endtask

    initial begin
        logic [63:0] rdata;
        logic [1:0]  resp;
        int          waits;

        // Reset state and waitrequest behaviour while held in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait_idle", {63'h0, a_wait}, 64'h0);
        a_read = 1'b1;
        #1;
        chk("rst_wait_req", {63'h0, a_wait}, 64'h1);
        a_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_readdata", {32'h0, a_readdata}, 64'h0);
        chk("rst_response", {62'h0, a_response}, 64'h0);
        chk("rst_readdata_b", b_readdata, 64'h0);

        vt.push_back(mk(0, 1, 32'hBFC00004, 32'hDEADBEEF, 4'hF, 32'h0,         2'b00,  3, 0));
        vt.push_back(mk(1, 0, 32'hBFC00004, 32'h0,        4'h0, 32'hDEADBEEF,  2'b00,  2, 1));
        vt.push_back(mk(0, 1, 32'hBFC00008, 32'h11223344, 4'hF, 32'h0,         2'b00,  3, 0));
        vt.push_back(mk(0, 1, 32'hBFC00008, 32'hAABBCCDD, 4'h5, 32'h0,         2'b00,  3, 0));
        vt.push_back(mk(1, 0, 32'hBFC00008, 32'h0,        4'h0, 32'h11BB33DD,  2'b00,  2, 1));
        vt.push_back(mk(0, 1, 32'hBFC0000C, 32'h5A5A5A5A, 4'hF, 32'h0,         2'b00,  3, 0));
        vt.push_back(mk(0, 1, 32'hBFC00010, 32'h01020304, 4'hF, 32'h0,         2'b00,  3, 0));
        vt.push_back(mk(0, 1, 32'hBFC00FFC, 32'h0A0B0C0D, 4'hF, 32'h0,         2'b00,  3, 0));
        vt.push_back(mk(1, 0, 32'hBFC00FFC, 32'h0,        4'h0, 32'h0A0B0C0D,  2'b00,  2, 1));
        vt.push_back(mk(1, 0, 32'hBFBFFFFC, 32'h0,        4'h0, 32'h0,         2'b10,  2, 1));
        vt.push_back(mk(1, 0, 32'hBFC01000, 32'h0,        4'h0, 32'h0,         2'b10,  2, 1));
        vt.push_back(mk(0, 1, 32'hBFC01000, 32'hCAFEF00D, 4'hF, 32'h0,         2'b10,  3, 1));
        vt.push_back(mk(1, 0, 32'hBFC00FFC, 32'h0,        4'h0, 32'h0A0B0C0D,  2'b00,  2, 1));
        vt.push_back(mk(1, 0, 32'hBFC00002, 32'h0,        4'h0, 32'h0,         2'b10,  2, 1));
        vt.push_back(mk(1, 1, 32'hBFC00004, 32'hFFFFFFFF, 4'hF, 32'h0,         2'b10, -1, 1));
        vt.push_back(mk(1, 0, 32'hBFC00004, 32'h0,        4'h0, 32'hDEADBEEF,  2'b00,  2, 1));
        vt.push_back(mk(0, 1, 32'hBFC00004, 32'h00000000, 4'h0, 32'h0,         2'b00,  3, 0));
        vt.push_back(mk(1, 0, 32'hBFC00004, 32'h0,        4'h0, 32'hDEADBEEF,  2'b00,  2, 1));
        vt.push_back(mk(1, 0, 32'hBFC0000C, 32'h0,        4'h0, 32'h5A5A5A5A,  2'b00,  2, 1));

        foreach (vt[i]) begin
            xfer(1'b0, vt[i].rd, vt[i].wr, vt[i].addr, {32'h0, vt[i].wd}, {4'h0, vt[i].be},
                 rdata, resp, waits);
            $display("vec %0d rd=%0b wr=%0b addr=%h wd=%h be=%h -> rdata=%h resp=%b waits=%0d",
                     i, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].be, rdata[31:0], resp, waits);
            chk($sformatf("vec%0d_resp", i), {62'h0, resp}, {62'h0, vt[i].exp_resp});
            if (vt[i].exp_w >= 0)
                chk($sformatf("vec%0d_waits", i), 64'(waits), 64'(vt[i].exp_w));
            if (vt[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), rdata, {32'h0, vt[i].exp_rd});
        end

        // Reset while a write sits in WAIT: write discarded, readdata cleared
        @(posedge clk); #1;
        a_address = 32'hBFC0000C; a_writedata = 32'h12345678; a_byteenable = 4'hF; a_write = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_write = 1'b0;
        @(negedge clk);
        $display("reset-in-wait: readdata=%h resp=%b", a_readdata, a_response);
        chk("rstwait_readdata", {32'h0, a_readdata}, 64'h0);
        chk("rstwait_response", {62'h0, a_response}, 64'h0);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC0000C, 64'h0, 8'h0, rdata, resp, waits);
        $display("read after reset-in-wait: rdata=%h resp=%b waits=%0d", rdata[31:0], resp, waits);
        chk("rstwait_old_value", rdata, 64'h5A5A5A5A);

        // Master abandons a write during WAIT: no commit, response stays OKAY
        @(posedge clk); #1;
        a_address = 32'hBFC00010; a_writedata = 32'hFFFF0000; a_byteenable = 4'hF; a_write = 1'b1;
        @(posedge clk); #1;
        a_write = 1'b0;
        @(negedge clk);
        chk("abort_response", {62'h0, a_response}, 64'h0);
        chk("abort_wait", {63'h0, a_wait}, 64'h0);
        xfer(1'b0, 1'b1, 1'b0, 32'hBFC00010, 64'h0, 8'h0, rdata, resp, waits);
        $display("read after abort: rdata=%h resp=%b waits=%0d", rdata[31:0], resp, waits);
        chk("abort_no_commit", rdata, 64'h01020304);

        // 64-bit instance, single wait state
        xfer(1'b1, 1'b0, 1'b1, 32'hBFC00000, 64'hFFEEDDCCBBAA9988, 8'hFF, rdata, resp, waits);
        $display("b write idx0: resp=%b waits=%0d", resp, waits);
        chk("b_w0_waits", 64'(waits), 64'd1);
        xfer(1'b1, 1'b0, 1'b1, 32'hBFC00008, 64'h0123456789ABCDEF, 8'hFF, rdata, resp, waits);
        $display("b write idx1: resp=%b waits=%0d", resp, waits);
        chk("b_w1_resp", {62'h0, resp}, 64'h0);
        xfer(1'b1, 1'b1, 1'b0, 32'hBFC00008, 64'h0, 8'h0, rdata, resp, waits);
        $display("b read idx1: rdata=%h resp=%b waits=%0d", rdata, resp, waits);
        chk("b_r1_waits", 64'(waits), 64'd1);
        chk("b_r1_rdata", rdata, 64'h0123456789ABCDEF);
        chk("b_r1_resp", {62'h0, resp}, 64'h0);
        xfer(1'b1, 1'b1, 1'b0, 32'hBFC00004, 64'h0, 8'h0, rdata, resp, waits);
        $display("b read misaligned: rdata=%h resp=%b waits=%0d", rdata, resp, waits);
        chk("b_mis_resp", {62'h0, resp}, 64'h2);
        chk("b_mis_rdata", rdata, 64'h0);
        xfer(1'b1, 1'b1, 1'b0, 32'hBFC00000, 64'h0, 8'h0, rdata, resp, waits);
        $display("b read idx0: rdata=%h resp=%b waits=%0d", rdata, resp, waits);
        chk("b_r0_rdata", rdata, 64'hFFEEDDCCBBAA9988);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
